// File: rtl/hit_cb_ser_scrubber_if.sv
// SRAM port bundle shared by the scrubber and the SER-protected circular buffer.
// The master side drives both chip enables, both addresses and the write-back data.
interface hit_cb_ser_scrubber_if #(
  parameter int AW = 7,
  parameter int DW = 4
);
  logic          CENA;
  logic [AW-1:0] AA;
  logic [DW-1:0] QA;
  logic          E1A;
  logic          E2A;
  logic          CENB;
  logic [AW-1:0] AB;
  logic [DW-1:0] DB;

  modport master (output CENA, AA, CENB, AB, DB, input QA, E1A, E2A);
  modport slave  (input CENA, AA, CENB, AB, DB, output QA, E1A, E2A);
endinterface

// File: rtl/hit_cb_ser_scrubber.sv
// Background SER scrubber: walks every word, rewrites single-bit errors through
// the encoder path and counts uncorrectable ones. Every output is a register.
module hit_cb_ser_scrubber #(
  parameter int AW             = 7,
  parameter int DW             = 4,
  parameter int SCRUB_INTERVAL = 1024,
  parameter int CW             = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  scrubEn,
  input  logic                  userReq,
  input  logic                  clearCounts,
  hit_cb_ser_scrubber_if.master sram,
  output logic                  scrubActive,
  output logic                  scrubDone,
  output logic [CW-1:0]         corrCount,
  output logic [CW-1:0]         uncorrCount,
  output logic [AW-1:0]         lastErrAddr
);

  localparam int TW = 16;
  localparam logic [TW-1:0] RELOAD = TW'(SCRUB_INTERVAL - 1);

  typedef enum logic [2:0] {IDLE, RD, CHK, WR, NXT} state_e;

  state_e          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [AW-1:0]   ptr_q, ptr_d;
  logic            cena_q, cena_d, cenb_q, cenb_d;
  logic [AW-1:0]   aa_q, aa_d, ab_q, ab_d, last_q, last_d;
  logic [DW-1:0]   db_q, db_d;
  logic            act_q, act_d, done_q, done_d;
  logic [CW-1:0]   corr_q, corr_d, unc_q, unc_d;
  logic            hit_corr, hit_unc;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; E2A alone is treated as uncorrectable, so only E1A&!E2A writes back
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (timer_q == '0 && scrubEn && !userReq) state_d = RD;
      RD:      state_d = CHK;
      CHK:     state_d = (sram.E1A && !sram.E2A) ? WR : NXT;
      WR:      state_d = NXT;
      NXT:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign hit_corr = (state_q == CHK) && sram.E1A && !sram.E2A;
  assign hit_unc  = (state_q == CHK) && sram.E2A;

  // Output / datapath next-state; outputs follow the state being entered
  always_comb begin
    timer_d = timer_q;
    if (state_q == NXT)                          timer_d = RELOAD;
    else if (state_q == IDLE && timer_q != '0)   timer_d = timer_q - TW'(1);

    ptr_d  = (state_q == NXT) ? ptr_q + AW'(1) : ptr_q;
    cena_d = (state_d != RD);
    cenb_d = (state_d != WR);
    aa_d   = (state_d == RD) ? ptr_q : aa_q;
    ab_d   = (state_d == WR) ? ptr_q : ab_q;
    db_d   = (state_d == WR) ? sram.QA : db_q;
    act_d  = (state_d == RD) || (state_d == CHK) || (state_d == WR);
    done_d = (state_d == NXT) && (ptr_q == '1);

    corr_d = corr_q;
    unc_d  = unc_q;
    last_d = last_q;
    if (hit_corr && corr_q != '1) corr_d = corr_q + CW'(1);
    if (hit_unc && unc_q != '1)   unc_d  = unc_q + CW'(1);
    if (hit_corr || hit_unc)      last_d = ptr_q;
    if (clearCounts) begin
      corr_d = '0;
      unc_d  = '0;
      last_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timer_q <= RELOAD;
      ptr_q   <= '0;
      cena_q  <= 1'b1;
      cenb_q  <= 1'b1;
      aa_q    <= '0;
      ab_q    <= '0;
      db_q    <= '0;
      act_q   <= 1'b0;
      done_q  <= 1'b0;
      corr_q  <= '0;
      unc_q   <= '0;
      last_q  <= '0;
    end else begin
      timer_q <= timer_d;
      ptr_q   <= ptr_d;
      cena_q  <= cena_d;
      cenb_q  <= cenb_d;
      aa_q    <= aa_d;
      ab_q    <= ab_d;
      db_q    <= db_d;
      act_q   <= act_d;
      done_q  <= done_d;
      corr_q  <= corr_d;
      unc_q   <= unc_d;
      last_q  <= last_d;
    end
  end

  assign sram.CENA   = cena_q;
  assign sram.AA     = aa_q;
  assign sram.CENB   = cenb_q;
  assign sram.AB     = ab_q;
  assign sram.DB     = db_q;
  assign scrubActive = act_q;
  assign scrubDone   = done_q;
  assign corrCount   = corr_q;
  assign uncorrCount = unc_q;
  assign lastErrAddr = last_q;

endmodule

// File: tb/tb_hit_cb_ser_scrubber.sv
// Directed-plus-random bench: an SRAM/SER model with injectable errors and a
// word-level scoreboard of the expected scrub walk, write-backs and counters.
module tb_hit_cb_ser_scrubber;
  localparam int AW = 7, DW = 4, INTV = 4, CW = 4;
  localparam int DEPTH = 1 << AW;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic reset, scrubEn, userReq, clearCounts;
  logic scrubActive, scrubDone;
  logic [CW-1:0] corrCount, uncorrCount;
  logic [AW-1:0] lastErrAddr;

  hit_cb_ser_scrubber_if #(.AW(AW), .DW(DW)) sif ();

  hit_cb_ser_scrubber #(.AW(AW), .DW(DW), .SCRUB_INTERVAL(INTV), .CW(CW)) dut (
    .clk(clk), .reset(reset), .scrubEn(scrubEn), .userReq(userReq),
    .clearCounts(clearCounts), .sram(sif), .scrubActive(scrubActive),
    .scrubDone(scrubDone), .corrCount(corrCount), .uncorrCount(uncorrCount),
    .lastErrAddr(lastErrAddr)
  );

  always #5 clk = ~clk;

  // Memory contents (true data) and injected error kind: 0 clean, 1 single, 2 double
  logic [DW-1:0] mem [DEPTH];
  int err [DEPTH];

  int n_chk = 0, n_pass = 0;
  int exp_ptr = 0, rd_addr = 0, n_rd = 0, n_wr = 0, n_done = 0, n_wb15 = 0;
  int n_missed = 0, n_spurious = 0;
  int m_corr = 0, m_unc = 0, m_last = 0;
  bit wr_pend = 0;

  task automatic chk(input string tag, input longint obs, input longint expv);
    n_chk++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
  endtask

  function automatic int sat(input int v);
    return (v < CMAX) ? v + 1 : v;
  endfunction

  task automatic monitor();
    if (sif.CENA == 1'b0) begin
      chk("read_addr", sif.AA, exp_ptr);
      if (wr_pend) n_missed++;
      rd_addr = exp_ptr;
      n_rd++;
      if (err[exp_ptr] == 1) begin
        m_corr = sat(m_corr); m_last = exp_ptr; wr_pend = 1;
      end else if (err[exp_ptr] == 2) begin
        m_unc = sat(m_unc); m_last = exp_ptr;
      end
      exp_ptr = (exp_ptr + 1) % DEPTH;
    end
    if (sif.CENB == 1'b0) begin
      n_wr++;
      if (sif.AB == 7'h15) n_wb15++;
      if (!wr_pend) n_spurious++;
      else begin
        chk("wb_addr", sif.AB, rd_addr);
        chk("wb_data", sif.DB, mem[rd_addr]);
      end
      wr_pend = 0;
    end
    if (scrubDone) begin
      n_done++;
      chk("done_after_last", rd_addr, DEPTH - 1);
    end
  endtask

  // One clock: SRAM model acts on the enables held during the cycle, then check outputs
  task automatic tick();
    logic cena, cenb;
    logic [AW-1:0] aa, ab;
    logic [DW-1:0] db;
    @(negedge clk);
    cena = sif.CENA; cenb = sif.CENB; aa = sif.AA; ab = sif.AB; db = sif.DB;
    @(posedge clk);
    #1;
    if (!cena) begin
      sif.QA  = (err[aa] == 2) ? DW'($urandom) : mem[aa];
      sif.E1A = (err[aa] != 0);
      sif.E2A = (err[aa] == 2);
    end
    if (!cenb) begin
      mem[ab] = db;
      err[ab] = 0;
    end
    monitor();
  endtask

  task automatic run_reads(input string tag, input int n, input int budget);
    int start, cyc;
    start = n_rd; cyc = 0;
    while ((n_rd - start) < n && cyc < budget) begin
      tick();
      cyc++;
    end
    chk(tag, n_rd - start, n);
  endtask

  task automatic drain();
    repeat (4) tick();
  endtask

  initial begin
    int a, nerr, viol, rd0, wr0;
    reset = 1'b0; scrubEn = 1'b0; userReq = 1'b0; clearCounts = 1'b0;
    sif.QA = '0; sif.E1A = 1'b0; sif.E2A = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = DW'($urandom);
      err[i] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("rst_CENA", sif.CENA, 1);
    chk("rst_CENB", sif.CENB, 1);
    chk("rst_AA", sif.AA, 0);
    chk("rst_AB", sif.AB, 0);
    chk("rst_DB", sif.DB, 0);
    chk("rst_active", scrubActive, 0);
    chk("rst_done", scrubDone, 0);
    chk("rst_corr", corrCount, 0);
    chk("rst_unc", uncorrCount, 0);
    chk("rst_last", lastErrAddr, 0);
    reset = 1'b1; scrubEn = 1'b1;

    // Clean pass over every address
    run_reads("clean_pass_reads", DEPTH, 2000);
    drain();
    chk("clean_writes", n_wr, 0);
    chk("clean_done_pulses", n_done, 1);
    chk("clean_corr", corrCount, 0);
    chk("clean_unc", uncorrCount, 0);

    // Single error at 0x15 plus a couple of random ones
    mem[7'h15] = 4'hA; err[7'h15] = 1;
    repeat (2) begin
      a = $urandom_range(7'h16, 7'h3f);
      mem[a] = DW'($urandom); err[a] = 1;
    end
    run_reads("single_pass_reads", DEPTH, 2000);
    drain();
    chk("single_wb15", n_wb15, 1);
    chk("single_mem15", mem[7'h15], 4'hA);
    chk("single_err15_cleared", err[7'h15], 0);
    chk("single_corr", corrCount, m_corr);
    chk("single_last", lastErrAddr, m_last);
    chk("single_unc", uncorrCount, 0);

    // Double error at 0x40: counted every pass, never written
    err[7'h40] = 2;
    wr0 = n_wr;
    run_reads("double_pass1_reads", DEPTH, 2000);
    drain();
    chk("double_no_write", n_wr - wr0, 0);
    chk("double_unc1", uncorrCount, 1);
    chk("double_last", lastErrAddr, 7'h40);
    chk("reread15_no_wb", n_wb15, 1);
    run_reads("double_pass2_reads", DEPTH, 2000);
    drain();
    chk("double_unc2", uncorrCount, 2);
    chk("double_unc_model", uncorrCount, m_unc);
    chk("double_done_pulses", n_done, 4);

    // userReq blocks step starts; the step already in flight completes
    run_reads("block_first_read", 1, 50);
    userReq = 1'b1;
    repeat (3) tick();
    rd0 = n_rd; viol = 0;
    repeat (50) begin
      tick();
      if (sif.CENA == 1'b0 || scrubActive) viol++;
    end
    chk("blocked_violations", viol, 0);
    chk("blocked_reads", n_rd - rd0, 0);
    userReq = 1'b0;
    tick();
    chk("release_CENA", sif.CENA, 0);
    chk("release_active", scrubActive, 1);
    drain();

    // Counter saturation, then clear colliding with a correction
    clearCounts = 1'b1;
    tick();
    clearCounts = 1'b0;
    m_corr = 0; m_unc = 0; m_last = 0;
    chk("clear_corr", corrCount, 0);
    chk("clear_unc", uncorrCount, 0);
    chk("clear_last", lastErrAddr, 0);
    nerr = 0;
    while (nerr < 20) begin
      a = $urandom_range(0, DEPTH - 1);
      if (a != 7'h40 && err[a] == 0) begin
        mem[a] = DW'($urandom); err[a] = 1; nerr++;
      end
    end
    run_reads("sat_pass_reads", DEPTH, 3000);
    drain();
    chk("sat_corr_max", corrCount, CMAX);
    chk("sat_corr_model", corrCount, m_corr);
    chk("sat_unc_model", uncorrCount, m_unc);
    chk("sat_last_model", lastErrAddr, m_last);

    err[exp_ptr] = 1;
    run_reads("clrcoll_read", 1, 50);
    tick();
    clearCounts = 1'b1;
    tick();
    clearCounts = 1'b0;
    chk("clrcoll_corr", corrCount, 0);
    chk("clrcoll_last", lastErrAddr, 0);
    m_corr = 0; m_unc = 0; m_last = 0;
    drain();

    // Reset asserted during WR
    err[exp_ptr] = 1;
    run_reads("rstwr_read", 1, 50);
    a = rd_addr;
    tick();
    tick();
    chk("rstwr_in_wr", sif.CENB, 0);
    reset = 1'b0;
    #1;
    chk("rstwr_CENB", sif.CENB, 1);
    chk("rstwr_active", scrubActive, 0);
    tick();
    chk("rstwr_no_write", err[a], 1);
    reset = 1'b1;
    exp_ptr = 0; wr_pend = 0; m_corr = 0; m_unc = 0; m_last = 0;
    run_reads("rstwr_restart", 1, 50);
    chk("rstwr_restart_AA", sif.AA, 0);
    drain();

    chk("missed_writebacks", n_missed, 0);
    chk("spurious_writes", n_spurious, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
